// File: rtl/rambam_ctrl_pkg.sv
// Shared types and helpers for the RAMBAM round sequencer.
// Holds the FSM state encoding, the round-constant seed and the GF(2^8) doubling.
package rambam_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_RAND,
    ST_SBOX,
    ST_UPDATE,
    ST_DONE
  } ctrl_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/rambam_rcon_gen.sv
// Round-constant register for the key expansion.
// init returns it to the first constant; advance steps it to the next round.
module rambam_rcon_gen
  import rambam_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       advance,
  output logic [7:0] rcon
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      rcon <= RCON_INIT;
    end else if (advance) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/rambam_round_ctrl.sv
// Sequencer for the masked AES-128 round datapath: load, NR randomness-gated rounds, done.
// Handshakes: start is taken on start_i && ready_o; randomness is taken on rand_req_o && rand_valid_i.
module rambam_round_ctrl
  import rambam_ctrl_pkg::*;
#(
  parameter int D        = 1,
  parameter int NR       = 10,
  parameter int SBOX_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        rand_req_o,
  input  logic        rand_valid_i,
  output logic        load_sel_o,
  output logic        state_we_o,
  output logic        key_we_o,
  output logic        sbox_en_o,
  output logic        mc_bypass_o,
  output logic [3:0]  round_o,
  output logic [7:0]  rcon_o,
  output logic        done_o,
  output ctrl_state_t state_o
);

  if (SBOX_LAT < 1 || SBOX_LAT > 15 || NR < 1 || NR > 15 || D < 0) begin : g_param_check
    $error("rambam_round_ctrl: SBOX_LAT must be 1..15, NR 1..15, D >= 0");
  end

  localparam logic [3:0] NR_L   = 4'(NR);
  localparam logic [3:0] LAT_M1 = 4'(SBOX_LAT - 1);

  ctrl_state_t state;
  logic [3:0]  lat_cnt;
  logic        rcon_init;
  logic        rcon_advance;

  // Every output is set for the state being entered, so it lines up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lat_cnt     <= 4'd0;
      round_o     <= 4'd0;
      ready_o     <= 1'b1;
      busy_o      <= 1'b0;
      rand_req_o  <= 1'b0;
      load_sel_o  <= 1'b0;
      state_we_o  <= 1'b0;
      key_we_o    <= 1'b0;
      sbox_en_o   <= 1'b0;
      mc_bypass_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      rand_req_o  <= 1'b0;
      load_sel_o  <= 1'b0;
      state_we_o  <= 1'b0;
      key_we_o    <= 1'b0;
      sbox_en_o   <= 1'b0;
      mc_bypass_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_LOAD;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
            load_sel_o <= 1'b1;
            state_we_o <= 1'b1;
            key_we_o   <= 1'b1;
          end
        end
        ST_LOAD: begin
          state      <= ST_WAIT_RAND;
          round_o    <= 4'd1;
          rand_req_o <= 1'b1;
        end
        ST_WAIT_RAND: begin
          if (rand_valid_i) begin
            state     <= ST_SBOX;
            lat_cnt   <= LAT_M1;
            sbox_en_o <= 1'b1;
          end else begin
            rand_req_o <= 1'b1;
          end
        end
        ST_SBOX: begin
          if (lat_cnt == 4'd0) begin
            state       <= ST_UPDATE;
            state_we_o  <= 1'b1;
            key_we_o    <= 1'b1;
            mc_bypass_o <= (round_o == NR_L);
          end else begin
            lat_cnt   <= lat_cnt - 4'd1;
            sbox_en_o <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (round_o == NR_L) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            state      <= ST_WAIT_RAND;
            round_o    <= round_o + 4'd1;
            rand_req_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          round_o <= 4'd0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          round_o <= 4'd0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  assign rcon_init    = (state == ST_DONE);
  assign rcon_advance = (state == ST_UPDATE) && (round_o != NR_L);
  assign state_o      = state;

  rambam_rcon_gen u_rcon (
    .clk     (clk),
    .rst     (rst),
    .init    (rcon_init),
    .advance (rcon_advance),
    .rcon    (rcon_o)
  );

endmodule

// File: tb/tb_rambam_round_ctrl.sv
// Bench for rambam_round_ctrl: schedule-level reference model, vector table, corner sequences.
// A second instance built with SBOX_LAT=1 checks the short-pipeline latency.
module tb_rambam_round_ctrl;
  import rambam_ctrl_pkg::*;

  localparam int NR   = 10;
  localparam int LAT  = 2;
  localparam int W    = 21;
  localparam int MAXC = 400;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_i, rand_valid_i;
  logic        ready_o, busy_o, rand_req_o, load_sel_o, state_we_o, key_we_o;
  logic        sbox_en_o, mc_bypass_o, done_o;
  logic [3:0]  round_o;
  logic [7:0]  rcon_o;
  ctrl_state_t state_o;

  logic        start1, rv1;
  logic        ready1, busy1, req1, ld1, swe1, kwe1, sb1, mcb1, done1;
  logic [3:0]  round1;
  logic [7:0]  rcon1;
  ctrl_state_t state1;

  rambam_round_ctrl #(.NR(NR), .SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ready_o(ready_o), .busy_o(busy_o),
    .rand_req_o(rand_req_o), .rand_valid_i(rand_valid_i), .load_sel_o(load_sel_o),
    .state_we_o(state_we_o), .key_we_o(key_we_o), .sbox_en_o(sbox_en_o),
    .mc_bypass_o(mc_bypass_o), .round_o(round_o), .rcon_o(rcon_o), .done_o(done_o),
    .state_o(state_o)
  );

  rambam_round_ctrl #(.NR(NR), .SBOX_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ready_o(ready1), .busy_o(busy1),
    .rand_req_o(req1), .rand_valid_i(rv1), .load_sel_o(ld1),
    .state_we_o(swe1), .key_we_o(kwe1), .sbox_en_o(sb1),
    .mc_bypass_o(mcb1), .round_o(round1), .rcon_o(rcon1), .done_o(done1),
    .state_o(state1)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  bit rv[0:MAXC-1];
  logic [7:0] rc_tab [0:10] = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  typedef struct {
    int wait_round;
    int wait_len;
    bit spam;
    int exp_done;
  } vec_t;
  vec_t tab[5];

  function automatic logic [W-1:0] pk(input logic rdy, bsy, req, ld, swe, kwe, sb, mcb, dn,
                                      input logic [3:0] rnd, input logic [7:0] rc);
    return {rdy, bsy, req, ld, swe, kwe, sb, mcb, dn, rnd, rc};
  endfunction

  function automatic logic [W-1:0] obs();
    return pk(ready_o, busy_o, rand_req_o, load_sel_o, state_we_o, key_we_o,
              sbox_en_o, mc_bypass_o, done_o, round_o, rcon_o);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected per-cycle outputs from cycle 1 (LOAD) to the IDLE cycle after DONE,
  // laid out from the round schedule and the rand_valid pattern in rv[].
  function automatic int build_exp();
    int t;
    exp_q.delete();
    exp_q.push_back(pk(0, 1, 0, 1, 1, 1, 0, 0, 0, 4'd0, 8'h01));
    t = 2;
    for (int r = 1; r <= NR; r++) begin
      while (!rv[t] && t < MAXC - 1) begin
        exp_q.push_back(pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 4'(r), rc_tab[r]));
        t++;
      end
      exp_q.push_back(pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 4'(r), rc_tab[r]));
      t++;
      for (int s = 0; s < LAT; s++) begin
        exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 1, 0, 0, 4'(r), rc_tab[r]));
        t++;
      end
      exp_q.push_back(pk(0, 1, 0, 0, 1, 1, 0, r == NR, 0, 4'(r), rc_tab[r]));
      t++;
    end
    exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4'(NR), rc_tab[NR]));
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h01));
    return t;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start_i = 1'b0; rand_valid_i = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input bit spam, output int done_seen, output int exp_done);
    int c;
    exp_done = build_exp();
    done_seen = -1;
    @(posedge clk); #1;
    start_i = 1'b1;
    rand_valid_i = rv[0];
    c = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      c++;
      start_i = spam;
      rand_valid_i = rv[c];
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, c), 32'(obs()), 32'(exp_q.pop_front()));
      if (done_o) done_seen = c;
    end
    if (spam) begin
      // start held through DONE and IDLE: only the IDLE-cycle request is taken
      @(posedge clk); #1;
      start_i = 1'b0;
      rand_valid_i = 1'b0;
      @(negedge clk);
      check({tag, " restart_load"}, 32'({load_sel_o, busy_o, round_o}), 32'({1'b1, 1'b1, 4'd0}));
      do_reset();
    end
    start_i = 1'b0;
    rand_valid_i = 1'b0;
  endtask

  initial begin
    int ds, ed, cyc, sb_cnt;
    rst = 1'b1; start_i = 1'b0; rand_valid_i = 1'b0; start1 = 1'b0; rv1 = 1'b1;
    tab[0] = '{0, 0, 0, 42};
    tab[1] = '{3, 5, 0, 47};
    tab[2] = '{1, 1, 0, 43};
    tab[3] = '{10, 2, 0, 44};
    tab[4] = '{7, 0, 1, 42};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h01)));
    check("reset_outputs_lat1",
          32'({ready1, busy1, req1, ld1, swe1, kwe1, sb1, mcb1, done1, round1, rcon1}),
          32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h01)));
    #1 rst = 1'b0;

    // vector table
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < MAXC; i++) rv[i] = 1'b1;
      if (tab[v].wait_round > 0)
        for (int i = 0; i < tab[v].wait_len; i++)
          rv[2 + (tab[v].wait_round - 1) * (LAT + 2) + i] = 1'b0;
      run_txn($sformatf("vec%0d", v), tab[v].spam, ds, ed);
      check($sformatf("vec%0d done_cycle", v), 32'(ds), 32'(tab[v].exp_done));
    end

    // reset during SBOX of round 4 (cycle 15), then a clean run
    for (int i = 0; i < MAXC; i++) rv[i] = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1; rand_valid_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("abort_pre_state", 32'({sbox_en_o, round_o, rcon_o}), 32'({1'b1, 4'd4, 8'h08}));
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_valid_i = 1'b0;
    @(negedge clk);
    check("abort_reset_vals", 32'(obs()), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h01)));
    run_txn("post_abort", 1'b0, ds, ed);
    check("post_abort done_cycle", 32'(ds), 32'd42);

    // randomized rand_valid patterns against the schedule model
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < MAXC; i++)
        rv[i] = (i % 8 == 7) ? 1'b1 : ($urandom_range(0, 3) != 0);
      run_txn($sformatf("rnd%0d", k), bit'($urandom_range(0, 1)), ds, ed);
      check($sformatf("rnd%0d done_cycle", k), 32'(ds), 32'(ed));
    end

    // SBOX_LAT=1 instance: 3-cycle rounds, done at cycle 32
    @(posedge clk); #1;
    start1 = 1'b1;
    cyc = 0; sb_cnt = 0; ds = -1;
    while (cyc < 100 && ds < 0) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc++;
      @(negedge clk);
      if (sb1) sb_cnt++;
      if (done1) ds = cyc;
    end
    check("lat1 done_cycle", 32'(ds), 32'd32);
    check("lat1 sbox_cycles", 32'(sb_cnt), 32'd10);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat1 ready_after", 32'({ready1, busy1, rcon1}), 32'({1'b1, 1'b0, 8'h01}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
